// File: rtl/dsm_ctrl.sv
// Delta-sigma modulator sequencing controller.
// Takes base-rate samples over valid/ready, holds each for OSR modulator
// clocks, drives an LFSR dither word, and sequences the modulator reset
// through flush, soft-start ramp, run and mute. T_BITS must not exceed 16
// because the dither word is sliced from the top of a 16-bit LFSR.
module dsm_ctrl #(
    parameter int T_BITS       = 15,
    parameter int OSR          = 64,
    parameter int FLUSH_CYCLES = 8,
    parameter int RAMP_STEPS   = 4,
    parameter int RAMP_SLOTS   = 16,
    parameter int MUTE_CYCLES  = 32,
    parameter int DITH_SHIFT   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              dither_en,
    input  logic [T_BITS-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [T_BITS-1:0] vin,
    output logic [T_BITS-1:0] dith,
    output logic              dsm_reset,
    output logic              running,
    output logic [7:0]        underrun_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_MUTE  = 3'd4
    } state_e;

    localparam int OSR_W = $clog2(OSR);
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int SL_W  = (RAMP_SLOTS > 1) ? $clog2(RAMP_SLOTS) : 1;
    localparam int MC_W  = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam int SH_W  = (RAMP_STEPS > 0) ? $clog2(RAMP_STEPS + 1) : 1;

    localparam logic [OSR_W-1:0] OSR_LAST   = OSR_W'(OSR - 1);
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [SL_W-1:0]  SLOT_LAST  = SL_W'(RAMP_SLOTS - 1);
    localparam logic [MC_W-1:0]  MUTE_LAST  = MC_W'(MUTE_CYCLES - 1);
    localparam logic [15:0]      LFSR_SEED  = 16'hACE1;

    state_e                    state_q, state_n;
    logic                      hold_valid, hold_valid_n;
    logic        [T_BITS-1:0]  hold;
    logic signed [T_BITS-1:0]  vin_reg;
    logic        [15:0]        lfsr;
    logic        [OSR_W-1:0]   osr_cnt;
    logic        [FC_W-1:0]    flush_cnt;
    logic        [SL_W-1:0]    slot_cnt;
    logic        [MC_W-1:0]    mute_cnt;
    logic        [SH_W-1:0]    ramp_shift;

    logic                      active, slot_end, accept, lfsr_fb;
    logic signed [T_BITS-1:0]  dith_src;

    assign active   = (state_q == S_RAMP) || (state_q == S_RUN);
    assign slot_end = active && (osr_cnt == OSR_LAST);
    assign accept   = in_valid && in_ready;
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign dith_src = $signed(lfsr[15 -: T_BITS]) >>> DITH_SHIFT;
    assign state    = state_q;

    // Next-state decode and hold-register occupancy for the coming cycle
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_n = S_FLUSH;
            S_FLUSH: begin
                if (!enable)
                    state_n = S_IDLE;
                else if (flush_cnt == FLUSH_LAST)
                    state_n = (RAMP_STEPS == 0) ? S_RUN : S_RAMP;
            end
            S_RAMP: begin
                if (!enable)
                    state_n = S_MUTE;
                else if (slot_end && slot_cnt == SLOT_LAST && ramp_shift == SH_W'(1))
                    state_n = S_RUN;
            end
            S_RUN:   if (!enable) state_n = S_MUTE;
            S_MUTE:  if (mute_cnt == MUTE_LAST) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        hold_valid_n = hold_valid;
        if (slot_end && hold_valid) hold_valid_n = 1'b0;
        if (accept)                 hold_valid_n = 1'b1;
        // Outside ramp/run the hold register is always empty; this also
        // discards a pending sample when muting.
        if (state_n != S_RAMP && state_n != S_RUN) hold_valid_n = 1'b0;
    end

    // Sequencer state, slot timing, sample path, dither and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dsm_reset    <= 1'b1;
            vin          <= '0;
            dith         <= '0;
            in_ready     <= 1'b0;
            running      <= 1'b0;
            underrun_cnt <= '0;
            hold_valid   <= 1'b0;
            hold         <= '0;
            vin_reg      <= '0;
            lfsr         <= LFSR_SEED;
            osr_cnt      <= '0;
            flush_cnt    <= '0;
            slot_cnt     <= '0;
            mute_cnt     <= '0;
            ramp_shift   <= '0;
        end else begin
            state_q    <= state_n;
            hold_valid <= hold_valid_n;
            in_ready   <= !hold_valid_n && (state_n == S_RAMP || state_n == S_RUN);
            dsm_reset  <= (state_n == S_IDLE) || (state_n == S_FLUSH);
            running    <= (state_n == S_RUN);

            if (accept) hold <= in_data;

            // vin and dith follow the current state, so they trail a change by one clock
            case (state_q)
                S_RAMP:  vin <= vin_reg >>> ramp_shift;
                S_RUN:   vin <= vin_reg;
                default: vin <= '0;
            endcase
            dith <= (dither_en && state_q != S_IDLE) ? dith_src : '0;

            if (state_q == S_IDLE) begin
                if (state_n == S_FLUSH) lfsr <= LFSR_SEED;
            end else begin
                lfsr <= {lfsr[14:0], lfsr_fb};
            end

            case (state_q)
                S_IDLE: begin
                    if (state_n == S_FLUSH) begin
                        underrun_cnt <= '0;
                        vin_reg      <= '0;
                        osr_cnt      <= '0;
                        flush_cnt    <= '0;
                    end
                end
                S_FLUSH: begin
                    flush_cnt <= flush_cnt + FC_W'(1);
                    if (state_n == S_RAMP || state_n == S_RUN) begin
                        ramp_shift <= SH_W'(RAMP_STEPS);
                        slot_cnt   <= '0;
                    end
                end
                S_RAMP, S_RUN: begin
                    osr_cnt <= slot_end ? '0 : osr_cnt + OSR_W'(1);
                    if (slot_end) begin
                        // Starved slot: repeat the previous sample and log it
                        if (hold_valid)
                            vin_reg <= hold;
                        else if (underrun_cnt != 8'hFF)
                            underrun_cnt <= underrun_cnt + 8'd1;
                        if (state_q == S_RAMP) begin
                            if (slot_cnt == SLOT_LAST) begin
                                slot_cnt   <= '0;
                                ramp_shift <= ramp_shift - SH_W'(1);
                            end else begin
                                slot_cnt <= slot_cnt + SL_W'(1);
                            end
                        end
                    end
                    if (state_n == S_MUTE) mute_cnt <= '0;
                end
                S_MUTE:  mute_cnt <= mute_cnt + MC_W'(1);
                default: ;
            endcase
        end
    end

endmodule
